switch_output_port: RTL and testbench
=====================================

Name: switch_output_port

Overview:
- Egress stage of switch_4port. One instance per output port sits directly downstream of the input ports and drives one port_if transmit side.
- Collects single-beat packets from the 4 ingress ports that target this port, arbitrates round-robin and buffers accepted packets in a FIFO.
- Presents packets on a valid/ready output and keeps accepted and dropped packet counters for the checker and coverage.

Parameters:
- DATA_W, 8, payload width in bits
- NUM_IN, 4, number of ingress ports (one-hot address width)
- PORT_ID, 0, index of this output port (0..NUM_IN-1)
- FIFO_DEPTH, 4, egress FIFO entries (power of 2, at least 2)
- PKT_W, 2*NUM_IN+DATA_W, packet width; fields {source[NUM_IN-1:0], target[NUM_IN-1:0], data[DATA_W-1:0]}, MSB first

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  NUM_IN  per-ingress packet valid
- in_pkt  in  NUM_IN*PKT_W  per-ingress packet; ingress i occupies bits [i*PKT_W +: PKT_W]
- in_ready  out  NUM_IN  per-ingress accept (grant), one-hot or zero
- out_valid  out  1  FIFO head valid
- out_pkt  out  PKT_W  FIFO head packet
- out_ready  in  1  downstream accept
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- acc_cnt  out  16  packets written to FIFO, saturating
- drop_cnt  out  16  malformed packets discarded, saturating

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: FIFO empty, fifo_count=0, out_valid=0, out_pkt=0, acc_cnt=0, drop_cnt=0, RR pointer=0, in_ready=0.
- Request: req[i] = in_valid[i] AND in_pkt[i].target[PORT_ID]. Packets not targeting PORT_ID are ignored and get no in_ready from this instance. Multicast packets are handled independently by each target instance.
- can_accept = (fifo_count < FIFO_DEPTH) OR (out_valid AND out_ready).
- Arbiter: when can_accept, grant the first req[i] found searching from the RR pointer upward with wrap-around.
  - in_ready = grant, combinational from current-cycle inputs.
  - At most one grant per cycle. No grant when can_accept is 0.
- RR pointer: on a grant to index g, the pointer becomes (g+1) mod NUM_IN at the next edge. Otherwise it is unchanged.
- Malformed packet: granted packet whose source is not exactly one-hot, or whose source bit equals PORT_ID (loopback).
  - Handshake completes normally (in_ready=1), but the packet is not written.
  - drop_cnt increments.
- Well-formed granted packet: written to the FIFO tail at the clock edge; acc_cnt increments.
- Latency: a packet accepted in cycle N is visible on out_valid/out_pkt in cycle N+1 at the earliest. There is no bypass path.
- Output: out_valid = FIFO not empty; out_pkt = FIFO head.
  - Pop on out_valid AND out_ready.
  - While out_valid=1 and out_ready=0, out_pkt holds stable.
- Simultaneous push and pop:
  - Allowed when full; fifo_count stays at FIFO_DEPTH.
  - Allowed when count=1; the new head appears the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH or goes below 0.
- Counters saturate at 16'hFFFF.
- Reset mid-operation: all buffered packets are discarded and counters cleared at the reset edge. in_ready=0 for the whole time rst_n=0.

Test Plan:
1. Single packet: ingress 1 sends {src=0010, tgt=0001, data=8'hA5} to PORT_ID=0, out_ready=1. Required: in_ready=0010 in the same cycle; out_valid the next cycle with out_pkt=0x21A5; acc_cnt=1.
2. Round-robin fairness: ingress 1, 2 and 3 all hold valid packets targeting port 0 continuously, out_ready=1. Required: grants follow 1,2,3,1,2,3; after 6 cycles acc_cnt=6 and each source has 2 packets delivered in order.
3. Backpressure/full: out_ready=0, 4 packets from ingress 2 (data 0..3). Required: fifo_count reaches 4 and in_ready stays 0 for the 5th packet. Then raise out_ready with the 5th still pending: push and pop occur in the same cycle, count holds at 4, outputs are data 0,1,2,3,4 in order.
4. Malformed and filtering:
   - src=0011 targeting port 0 -> granted; drop_cnt=1; acc_cnt unchanged; out_valid stays 0.
   - src=0001 (loopback) -> drop_cnt=2.
   - tgt=0100 -> in_ready stays 0.
5. Reset mid-stream: 3 packets buffered, rst_n=0 for 1 cycle. Required: fifo_count=0, out_valid=0, acc_cnt=0, RR pointer=0 after the edge. The next request from ingress 3 is granted normally.
6. Saturation: force 65,537 well-formed accepts. Required: acc_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/switch_output_port.sv
// rtl/switch_output_port.sv - egress stage: round-robin ingress arbiter, malformed-packet filter, egress FIFO, counters
module switch_output_port #(
  parameter int DATA_W     = 8,
  parameter int NUM_IN     = 4,
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_W      = 2*NUM_IN+DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_IN-1:0]             in_valid,
  input  logic [NUM_IN*PKT_W-1:0]       in_pkt,
  output logic [NUM_IN-1:0]             in_ready,
  output logic                          out_valid,
  output logic [PKT_W-1:0]              out_pkt,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   acc_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [PKT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  rr_ptr, next_ptr;
  logic [NUM_IN-1:0] req, grant, src;
  logic [PKT_W-1:0]  gnt_pkt;
  logic              any_grant, can_accept, well_formed, push, pop;

  assign out_valid  = (fifo_count != '0);
  assign out_pkt    = out_valid ? mem[rd_ptr] : '0;
  assign pop        = out_valid && out_ready;
  // Holding reset low also blocks grants, so nothing is handshaken while in reset.
  assign can_accept = rst_n && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
  assign in_ready   = grant;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_IN; i++)
      req[i] = in_valid[i] & in_pkt[i*PKT_W + DATA_W + PORT_ID];
  end

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    next_ptr  = rr_ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_IN;
      if (!any_grant && can_accept && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
        next_ptr   = IDX_W'((idx + 1) % NUM_IN);
      end
    end
  end

  always_comb begin
    gnt_pkt = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (grant[i]) gnt_pkt = in_pkt[i*PKT_W +: PKT_W];
  end

  // Source must be exactly one-hot and must not be this port (loopback).
  assign src         = gnt_pkt[DATA_W+NUM_IN +: NUM_IN];
  assign well_formed = (src != '0) && ((src & (src - NUM_IN'(1))) == '0) && !src[PORT_ID];
  assign push        = any_grant && well_formed;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gnt_pkt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rr_ptr     <= '0;
      acc_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (any_grant) rr_ptr <= next_ptr;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
      if (push && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      if (any_grant && !well_formed && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_switch_output_port.sv
// tb/tb_switch_output_port.sv - directed self-checking bench for switch_output_port (PORT_ID=0)
module tb_switch_output_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [63:0] in_pkt;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_pkt;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic [15:0] acc_cnt;
  logic [15:0] drop_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  switch_output_port dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pkt(in_pkt), .in_ready(in_ready),
    .out_valid(out_valid), .out_pkt(out_pkt), .out_ready(out_ready),
    .fifo_count(fifo_count), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    return {s, t, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [15:0] p, input logic v);
    in_pkt[i*16 +: 16] = p;
    in_valid[i] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_pkt = '0; out_ready = 1'b0;
    step();
    set_in(1, mk(4'b0010, 4'b0001, 8'h11), 1'b1);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("reset_count", 32'(fifo_count), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_pkt", 32'(out_pkt), 32'h0);
    chk("reset_acc", 32'(acc_cnt), 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    in_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_in(1, mk(4'b0010, 4'b0001, 8'hA5), 1'b1);
    out_ready = 1'b1;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'h2);
    chk("single_no_bypass", 32'(out_valid), 32'h0);
    step();
    in_valid = '0;
    #1;
    chk("single_out_valid", 32'(out_valid), 32'h1);
    chk("single_out_pkt", 32'(out_pkt), 32'h21A5);
    chk("single_acc", 32'(acc_cnt), 32'h1);
    step();
    chk("single_drained", 32'(out_valid), 32'h0);
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_q[$];
    logic [3:0]  exp_gnt [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    int          n [4] = '{0, 0, 0, 0};
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 1; i < 4; i++)
        set_in(i, mk(4'(1 << i), 4'b0001, 8'(i*16 + n[i])), c < 6);
      #1;
      if (c < 6) begin
        chk($sformatf("rr_grant%0d", c), 32'(in_ready), 32'(exp_gnt[c]));
        for (int i = 1; i < 4; i++)
          if (exp_gnt[c][i]) begin
            exp_q.push_back(mk(4'(1 << i), 4'b0001, 8'(i*16 + n[i])));
            n[i]++;
          end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("rr_unexpected_out", 32'(out_pkt), 32'hFFFF_FFFF);
        else chk($sformatf("rr_out%0d", c), 32'(out_pkt), 32'(exp_q.pop_front()));
      end
      step();
    end
    chk("rr_all_delivered", 32'(exp_q.size()), 32'h0);
    chk("rr_acc", 32'(acc_cnt), 32'd6);
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid = '0;
    for (int d = 0; d < 4; d++) begin
      set_in(2, mk(4'b0100, 4'b0001, 8'(d)), 1'b1);
      #1;
      chk($sformatf("full_grant%0d", d), 32'(in_ready), 32'h4);
      step();
    end
    set_in(2, mk(4'b0100, 4'b0001, 8'd4), 1'b1);
    #1;
    chk("full_count4", 32'(fifo_count), 32'd4);
    chk("full_blocked", 32'(in_ready), 32'h0);
    chk("full_head0", 32'(out_pkt), 32'h4100);
    step();
    chk("full_still_blocked", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("full_pushpop_grant", 32'(in_ready), 32'h4);
    step();
    in_valid = '0;
    chk("full_count_hold", 32'(fifo_count), 32'd4);
    for (int d = 1; d < 5; d++) begin
      chk($sformatf("full_out%0d", d), 32'(out_pkt), 32'(mk(4'b0100, 4'b0001, 8'(d))));
      step();
    end
    chk("full_empty", 32'(out_valid), 32'h0);
    chk("full_acc", 32'(acc_cnt), 32'd11);
  endtask

  task automatic test_malformed();
    set_in(1, mk(4'b0011, 4'b0001, 8'h5A), 1'b1);
    #1;
    chk("mal_multi_src_grant", 32'(in_ready), 32'h2);
    step();
    in_valid = '0;
    chk("mal_drop1", 32'(drop_cnt), 32'd1);
    chk("mal_acc_same", 32'(acc_cnt), 32'd11);
    chk("mal_no_out", 32'(out_valid), 32'h0);
    set_in(1, mk(4'b0001, 4'b0001, 8'h5B), 1'b1);
    #1;
    chk("mal_loop_grant", 32'(in_ready), 32'h2);
    step();
    in_valid = '0;
    chk("mal_drop2", 32'(drop_cnt), 32'd2);
    set_in(1, mk(4'b0010, 4'b0100, 8'h5C), 1'b1);
    #1;
    chk("mal_filter", 32'(in_ready), 32'h0);
    step();
    in_valid = '0;
    chk("mal_filter_drop", 32'(drop_cnt), 32'd2);
    chk("mal_filter_acc", 32'(acc_cnt), 32'd11);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_in(2, mk(4'b0100, 4'b0001, 8'(d)), 1'b1);
      step();
    end
    chk("mid_count3", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    in_valid = '0;
    chk("mid_count0", 32'(fifo_count), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'h0);
    chk("mid_acc", 32'(acc_cnt), 32'd0);
    chk("mid_drop", 32'(drop_cnt), 32'd0);
    set_in(1, mk(4'b0010, 4'b0001, 8'h71), 1'b1);
    set_in(3, mk(4'b1000, 4'b0001, 8'h73), 1'b1);
    #1;
    chk("mid_rr_ptr0", 32'(in_ready), 32'h2);
    step();
    in_valid[1] = 1'b0;
    #1;
    chk("mid_ingress3", 32'(in_ready), 32'h8);
    step();
    in_valid = '0;
    chk("mid_acc2", 32'(acc_cnt), 32'd2);
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b1;
    set_in(1, mk(4'b0010, 4'b0001, 8'h33), 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(acc_cnt), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(acc_cnt), 32'hFFFF);
    step(); step();
    chk("sat_hold", 32'(acc_cnt), 32'hFFFF);
    chk("sat_count1", 32'(fifo_count), 32'd1);
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_malformed();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
